// File: rtl/test_checker_pkg.sv
// Shared types for the test-episode sequencer: FSM states and run modes.
package test_checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_START,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_EARLY = 1'b1;

endpackage

// File: rtl/test_check_lane.sv
// One check lane: shadows a single core register from the writeback port
// and compares it against the expected value.
module test_check_lane
    import test_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_INDEX_BITS = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      capture_i,
    input  logic                      wb_valid_i,
    input  logic [REG_INDEX_BITS-1:0] wb_index_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic [REG_INDEX_BITS-1:0] index_i,
    input  logic [DATA_WIDTH-1:0]     expected_i,
    output logic                      match_o,
    output logic [DATA_WIDTH-1:0]     shadow_o
);

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  hit;

    // x0 is hardwired to zero in the core, so writes to it never land
    assign hit = capture_i & wb_valid_i
               & (wb_index_i != '0)
               & (wb_index_i == index_i);

    always_comb begin
        shadow_d = shadow_q;
        if (clear_i) begin
            shadow_d = '0;
        end else if (hit) begin
            shadow_d = wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign match_o  = (shadow_q == expected_i);
    assign shadow_o = shadow_q;

endmodule

// File: rtl/test_sequence_checker.sv
// Test-episode sequencer: resets and starts the core, snoops writeback
// for a bounded run, then reports per-lane register check results.
module test_sequence_checker
    import test_checker_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int REG_INDEX_BITS = 5,
    parameter int CYCLE_BITS     = 24,
    parameter int RESET_CYCLES   = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               run,
    input  logic                               mode,
    input  logic [CYCLE_BITS-1:0]              timeout_cycles,
    input  logic [NUM_CHECKS-1:0]              check_enable,
    input  logic [NUM_CHECKS*REG_INDEX_BITS-1:0] check_index,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]   check_value,
    input  logic                               wb_valid,
    input  logic [REG_INDEX_BITS-1:0]          wb_index,
    input  logic [DATA_WIDTH-1:0]              wb_data,
    output logic                               core_reset,
    output logic                               core_start,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               timeout_flag,
    output logic [NUM_CHECKS-1:0]              mismatch_mask,
    output logic [CYCLE_BITS-1:0]              cycle_count
);

    localparam int HB = $clog2(RESET_CYCLES + 1);

    state_e                state_q;
    logic [HB-1:0]         hold_q;
    logic                  all_match_q;
    logic                  all_match_d;
    logic                  clear;
    logic                  capture;
    logic [CYCLE_BITS-1:0] last_cc;
    logic [NUM_CHECKS-1:0] match;
    logic [NUM_CHECKS-1:0] mismatch_d;
    logic [DATA_WIDTH-1:0] shadow [NUM_CHECKS];

    assign clear   = ((state_q == S_IDLE) || (state_q == S_DONE)) & run;
    assign capture = (state_q == S_START) || (state_q == S_RUN);
    assign last_cc = (timeout_cycles == '0) ? '0
                   : timeout_cycles - CYCLE_BITS'(1);

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_lane
        test_check_lane #(
            .DATA_WIDTH    (DATA_WIDTH),
            .REG_INDEX_BITS(REG_INDEX_BITS)
        ) u_lane (
            .clk_i     (clock),
            .rst_ni    (reset),
            .clear_i   (clear),
            .capture_i (capture),
            .wb_valid_i(wb_valid),
            .wb_index_i(wb_index),
            .wb_data_i (wb_data),
            .index_i   (check_index[i*REG_INDEX_BITS +: REG_INDEX_BITS]),
            .expected_i(check_value[i*DATA_WIDTH +: DATA_WIDTH]),
            .match_o   (match[i]),
            .shadow_o  (shadow[i])
        );
    end

    always_comb begin
        mismatch_d = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            mismatch_d[i] = check_enable[i]
                & (shadow[i] != check_value[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // disabled lanes count as matched, so an empty mask matches at once
    assign all_match_d = &(~check_enable | match);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            all_match_q   <= 1'b0;
            core_reset    <= 1'b1;
            core_start    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout_flag  <= 1'b0;
            mismatch_mask <= '0;
            cycle_count   <= '0;
        end else begin
            all_match_q <= all_match_d;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        state_q       <= S_HOLD;
                        hold_q        <= '0;
                        core_reset    <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout_flag  <= 1'b0;
                        mismatch_mask <= '0;
                        cycle_count   <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HB'(RESET_CYCLES - 1)) begin
                        state_q     <= S_START;
                        core_reset  <= 1'b0;
                        core_start  <= 1'b1;
                        cycle_count <= '0;
                    end else begin
                        hold_q <= hold_q + HB'(1);
                    end
                end
                S_START: begin
                    state_q    <= S_RUN;
                    core_start <= 1'b0;
                end
                S_RUN: begin
                    cycle_count <= cycle_count + CYCLE_BITS'(1);
                    if ((cycle_count == last_cc) ||
                        ((mode == MODE_EARLY) && all_match_q)) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_q       <= S_DONE;
                    mismatch_mask <= mismatch_d;
                    pass          <= ~|mismatch_d;
                    timeout_flag  <= mode & (|mismatch_d);
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    core_reset    <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequence_checker.sv
// Randomized and directed episodes checked against a cycle-level
// reference model of the episode rules.
module tb_test_sequence_checker;

    localparam int DW   = 32;
    localparam int NC   = 4;
    localparam int RB   = 5;
    localparam int CB   = 24;
    localparam int RC   = 8;
    localparam int MAXC = 1100;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              run = 1'b0;
    logic              mode = 1'b0;
    logic [CB-1:0]     timeout_cycles = '0;
    logic [NC-1:0]     check_enable = '0;
    logic [NC*RB-1:0]  check_index = '0;
    logic [NC*DW-1:0]  check_value = '0;
    logic              wb_valid = 1'b0;
    logic [RB-1:0]     wb_index = '0;
    logic [DW-1:0]     wb_data = '0;
    logic              core_reset, core_start, busy, done;
    logic              pass, timeout_flag;
    logic [NC-1:0]     mismatch_mask;
    logic [CB-1:0]     cycle_count;

    test_sequence_checker #(
        .DATA_WIDTH(DW), .NUM_CHECKS(NC), .REG_INDEX_BITS(RB),
        .CYCLE_BITS(CB), .RESET_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .mode(mode),
        .timeout_cycles(timeout_cycles), .check_enable(check_enable),
        .check_index(check_index), .check_value(check_value),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .core_reset(core_reset), .core_start(core_start), .busy(busy),
        .done(done), .pass(pass), .timeout_flag(timeout_flag),
        .mismatch_mask(mismatch_mask), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write schedule, indexed by cycle number counted from the START cycle
    bit            sv [MAXC];
    logic [RB-1:0] si [MAXC];
    logic [DW-1:0] sd [MAXC];
    logic [DW-1:0] m_sh [NC];

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) sv[i] = 0;
    endtask

    task automatic add_w(input int c, input int idx, input logic [DW-1:0] d);
        sv[c] = 1;
        si[c] = RB'(idx);
        sd[c] = d;
    endtask

    function automatic bit m_match();
        bit r = 1;
        for (int i = 0; i < NC; i++)
            if (check_enable[i] && m_sh[i] != check_value[i*DW +: DW]) r = 0;
        return r;
    endfunction

    task automatic m_apply(input int c);
        if (c < MAXC && sv[c] && si[c] != 0)
            for (int i = 0; i < NC; i++)
                if (si[c] == check_index[i*RB +: RB]) m_sh[i] = sd[c];
    endtask

    // shadows seen in cycle c reflect writes of cycles < c; the early-exit
    // decision in cycle c sees the match of the shadows of cycle c-1
    task automatic model(output int ex, output logic [NC-1:0] mm);
        int lim;
        bit mlag, e;
        lim = (timeout_cycles == 0) ? 1 : int'(timeout_cycles);
        for (int i = 0; i < NC; i++) m_sh[i] = '0;
        mlag = m_match();
        m_apply(0);
        ex = lim;
        for (int c = 1; c <= lim; c++) begin
            e = (c == lim) || (mode && mlag);
            mlag = m_match();
            m_apply(c);
            if (e) begin
                ex = c;
                break;
            end
        end
        for (int i = 0; i < NC; i++)
            mm[i] = check_enable[i] && (m_sh[i] != check_value[i*DW +: DW]);
    endtask

    // pulse run, check the HOLD window; returns at the START negedge
    task automatic launch(input string tag, input bit hold_wr);
        int hc = 0;
        @(negedge clock);
        run = 1;
        @(negedge clock);
        run = 0;
        chk({tag, " busy"}, busy, 1);
        chk({tag, " done_low"}, done, 0);
        while (!core_start && hc < 50) begin
            if (core_reset && busy) hc++;
            wb_valid = hold_wr && (hc == 4);
            wb_index = check_index[RB-1:0];
            wb_data  = check_value[DW-1:0];
            @(negedge clock);
        end
        wb_valid = 0;
        chk({tag, " hold_len"}, hc, RC);
        chk({tag, " start_rst"}, core_reset, 0);
    endtask

    task automatic episode(input string tag, input bit hold_wr,
                           input int run_at_in);
        int ex, c, run_at;
        logic [NC-1:0] mm;
        bit ep;
        model(ex, mm);
        ep = (mm == 0);
        run_at = (run_at_in > ex) ? -1 : run_at_in;
        launch(tag, hold_wr);
        c = 0;
        while (!done && c < ex + 10) begin
            if (c < MAXC && sv[c]) begin
                wb_valid = 1;
                wb_index = si[c];
                wb_data  = sd[c];
            end else begin
                wb_valid = 0;
            end
            run = (c == run_at);
            @(negedge clock);
            c++;
            if (c == 1) chk({tag, " start_pulse"}, core_start, 0);
        end
        wb_valid = 0;
        run = 0;
        chk({tag, " done_cyc"}, c, ex + 2);
        chk({tag, " cycles"}, cycle_count, ex);
        chk({tag, " pass"}, pass, ep);
        chk({tag, " mask"}, mismatch_mask, mm);
        chk({tag, " tmo"}, timeout_flag, mode & ~ep);
        chk({tag, " parked"}, {core_reset, busy}, 2'b10);
    endtask

    task automatic setlane(input int i, input int idx, input logic [DW-1:0] v);
        check_index[i*RB +: RB] = RB'(idx);
        check_value[i*DW +: DW] = v;
    endtask

    initial begin
        #12;
        chk("rst core_reset", core_reset, 1);
        chk("rst outs", {core_start, busy, done, pass, timeout_flag}, 0);
        chk("rst mask", mismatch_mask, 0);
        chk("rst cc", cycle_count, 0);
        @(negedge clock);
        reset = 1;

        // fixed length, write then correct value, run poked mid-RUN
        clear_sched();
        mode = 0; timeout_cycles = 100; check_enable = 4'b0001;
        setlane(0, 9, 5);
        add_w(20, 9, 3); add_w(60, 9, 5);
        episode("fixed_pass", 0, 30);

        clear_sched();
        mode = 0; timeout_cycles = 50; check_enable = 4'b0010;
        setlane(1, 10, 32'hDEADBEEF);
        add_w(10, 10, 32'hDEADBEEE);
        episode("fixed_miss", 0, -1);

        clear_sched();
        mode = 1; timeout_cycles = 1000; check_enable = 4'b0011;
        setlane(0, 3, 32'h11); setlane(1, 4, 32'h22);
        add_w(15, 3, 32'h11); add_w(40, 4, 32'h22);
        episode("early_hit", 0, -1);

        clear_sched();
        episode("early_tmo", 0, -1);

        clear_sched();
        mode = 0; timeout_cycles = 20; check_enable = 4'b0001;
        setlane(0, 0, 7);
        add_w(5, 0, 7);
        episode("x0_ignored", 0, -1);

        clear_sched();
        mode = 1; timeout_cycles = 500; check_enable = 4'b0000;
        episode("empty_mask", 0, -1);

        clear_sched();
        mode = 0; timeout_cycles = 0; check_enable = 4'b0001;
        setlane(0, 9, 0);
        episode("tmo_zero", 0, -1);

        clear_sched();
        mode = 0; timeout_cycles = 20; check_enable = 4'b0001;
        setlane(0, 9, 5);
        episode("hold_write", 1, -1);

        // reset mid-episode, then a clean episode
        clear_sched();
        mode = 0; timeout_cycles = 100; check_enable = 4'b0001;
        setlane(0, 9, 0);
        launch("abort", 0);
        for (int c = 0; c < 30; c++) begin
            wb_valid = (c == 2);
            wb_index = 9;
            wb_data  = 32'h55;
            @(negedge clock);
        end
        wb_valid = 0;
        reset = 0;
        #1;
        chk("abort core_reset", core_reset, 1);
        chk("abort outs", {core_start, busy, done, pass, timeout_flag}, 0);
        chk("abort mask", mismatch_mask, 0);
        chk("abort cc", cycle_count, 0);
        @(negedge clock);
        reset = 1;
        timeout_cycles = 10;
        episode("after_abort", 0, -1);

        for (int n = 0; n < 20; n++) begin
            clear_sched();
            mode = 1'($urandom);
            timeout_cycles = CB'($urandom_range(1, 200));
            check_enable = NC'($urandom);
            for (int i = 0; i < NC; i++)
                setlane(i, $urandom_range(0, 7), DW'($urandom_range(0, 3)));
            for (int c = 0; c < 210; c++)
                if ($urandom_range(0, 3) == 0)
                    add_w(c, $urandom_range(0, 7), DW'($urandom_range(0, 3)));
            episode($sformatf("rand%0d", n), 1'($urandom), 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
